// File: rtl/wb_sequencer_pkg.sv
// Shared definitions for the writeback sequencer: MemToReg source codes and FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wb_sequencer_pkg;

  // MemToReg mux source codes
  localparam logic [3:0] MTR_ALU   = 4'd0;  // ALUOut
  localparam logic [3:0] MTR_LS    = 4'd1;  // LSControl_Out (memory wait states)
  localparam logic [3:0] MTR_IMM   = 4'd2;  // immediate shifted left 16
  localparam logic [3:0] MTR_HI    = 4'd3;  // mult/div HI
  localparam logic [3:0] MTR_LO    = 4'd4;  // mult/div LO
  localparam logic [3:0] MTR_CONST = 4'd5;  // constant 227
  localparam logic [3:0] MTR_SEXT  = 4'd6;  // sign-extended immediate
  localparam logic [3:0] MTR_SHIFT = 4'd7;  // shift register
  localparam logic [3:0] MTR_B     = 4'd8;  // register B
  localparam logic [3:0] MTR_A     = 4'd9;  // register A

  // Codes above this have no mux input behind them
  localparam logic [3:0] MTR_MAX_LEGAL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERR   = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_sequencer_wait_counter.sv
// 8-bit wait counter with synchronous clear/enable and an equality compare against a limit.
// Latency: count updates one cycle after enable; at_limit_o is combinational from the count.
// Backpressure: none; clear has priority over enable.
//   clk, reset_n : clock, synchronous active-low reset
//   clr_i, en_i  : clear to zero / increment by one
//   limit_i      : compare value; at_limit_o high while count == limit_i
module wb_wait_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] limit_i,
  output logic       at_limit_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == limit_i);

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: latches a MemToReg select + dest reg, waits for the source to be valid, pulses RegWrite.
// Latency: accept edge to reg_write 1 cycle (immediate), MEM_WAIT cycles (LSCtrl), or done+1 (HI/LO/shift).
// Backpressure: wb_req only sampled in IDLE; wb_ack pulses on acceptance, busy high outside IDLE.
//   in : clk, reset_n, wb_req, wb_src[3:0], wb_dst[4:0], md_done, shift_done, flush
//   out: wb_ack, mem_to_reg[3:0], reg_write, write_reg[4:0], busy, wb_done, wb_err
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int MEM_WAIT = 2,   // 1..15
  parameter int TIMEOUT  = 64   // 2..255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wb_req,
  input  logic [3:0] wb_src,
  input  logic [4:0] wb_dst,
  input  logic       md_done,
  input  logic       shift_done,
  input  logic       flush,
  output logic       wb_ack,
  output logic [3:0] mem_to_reg,
  output logic       reg_write,
  output logic [4:0] write_reg,
  output logic       busy,
  output logic       wb_done,
  output logic       wb_err
);

  localparam logic [7:0] MEM_LIM = 8'(MEM_WAIT - 1);
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT - 1);

  wb_state_e  state_q, state_d;
  logic [3:0] mtr_q, mtr_d;
  logic [4:0] wreg_q, wreg_d;
  logic       ack_q, ack_d;
  logic       accept;
  logic       src_ready;
  logic       use_timeout;
  logic       at_limit;
  logic [7:0] cnt_limit;

  // One counter serves both the fixed memory wait and the done-flag timeout;
  // the latched code picks which limit it compares against.
  assign cnt_limit = (mtr_q == MTR_LS) ? MEM_LIM : TO_LIM;

  wb_wait_counter u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (accept),
    .en_i       (state_q == ST_WAIT),
    .limit_i    (cnt_limit),
    .at_limit_o (at_limit)
  );

  // Source-ready decode on the latched code
  always_comb begin
    src_ready   = 1'b0;
    use_timeout = 1'b0;
    case (mtr_q)
      MTR_ALU, MTR_IMM, MTR_CONST, MTR_SEXT, MTR_B, MTR_A: src_ready = 1'b1;
      MTR_LS:         src_ready = at_limit;
      MTR_HI, MTR_LO: begin
        src_ready   = md_done;
        use_timeout = 1'b1;
      end
      MTR_SHIFT: begin
        src_ready   = shift_done;
        use_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mtr_d   = mtr_q;
    wreg_d  = wreg_q;
    ack_d   = 1'b0;
    accept  = 1'b0;
    // flush in IDLE also lands here, which is what blocks acceptance that cycle
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wb_req) begin
            accept  = 1'b1;
            ack_d   = 1'b1;
            mtr_d   = wb_src;
            wreg_d  = wb_dst;
            state_d = (wb_src > MTR_MAX_LEGAL) ? ST_ERR : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // ready is tested first so a done flag on the limit cycle still writes
          if (src_ready) begin
            state_d = ST_WRITE;
          end else if (use_timeout && at_limit) begin
            state_d = ST_ERR;
          end
        end
        ST_WRITE: state_d = ST_IDLE;
        ST_ERR:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mtr_q   <= 4'd0;
      wreg_q  <= 5'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mtr_q   <= mtr_d;
      wreg_q  <= wreg_d;
      ack_q   <= ack_d;
    end
  end

  assign wb_ack     = ack_q;
  assign mem_to_reg = mtr_q;
  assign write_reg  = wreg_q;
  assign busy       = (state_q != ST_IDLE);
  // $zero is never written, but the request still completes
  assign reg_write  = (state_q == ST_WRITE) && (wreg_q != 5'd0);
  assign wb_done    = (state_q == ST_WRITE) || (state_q == ST_ERR);
  assign wb_err     = (state_q == ST_ERR);

endmodule
